// File: rtl/mem_port_arbiter.sv
// Arbitrates the single mainMem port between fetch (read-only) and data
// (read/write) requesters, sequencing bursts beat by beat.
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic [1:0]  f_acc_size,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_acc_size,
  input  logic [31:0] d_wdata,
  output logic        d_wnext,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_wren,
  output logic [1:0]  mem_acc_size,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy
);

  localparam int L  = READ_LATENCY;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          own_q, own_d;
  logic          we_q, we_d;
  logic [31:0]   base_q, base_d;
  logic [1:0]    size_q, size_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          fg_q, fg_d;
  logic          dg_q, dg_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [L-1:0]  pv_q, pv_d;
  logic [L-1:0]  po_q, po_d;

  logic burst;
  logic acc;
  logic rv;
  logic pipe_busy;
  logic d_win;

  function automatic logic [3:0] last_beat(input logic [1:0] s);
    logic [3:0] r;
    case (s)
      2'b00:   r = 4'd0;
      2'b01:   r = 4'd3;
      2'b10:   r = 4'd7;
      default: r = 4'd15;
    endcase
    return r;
  endfunction

  assign burst = (state_q == S_BURST);
  assign acc   = burst & ~mem_busy;

  assign mem_enable   = burst;
  assign mem_wren     = burst & we_q;
  assign mem_addr     = burst ? base_q + {26'd0, k_q, 2'b00} : '0;
  assign mem_data_in  = mem_wren ? d_wdata : '0;
  assign mem_acc_size = size_q;
  assign d_wnext      = acc & we_q;

  // Owner tag travels with each read beat so returns route correctly.
  assign rv       = pv_q[L-1];
  assign f_rvalid = rv & ~po_q[L-1];
  assign d_rvalid = rv & po_q[L-1];
  assign f_rdata  = f_rvalid ? mem_data_out : '0;
  assign d_rdata  = d_rvalid ? mem_data_out : '0;
  assign f_gnt    = fg_q;
  assign d_gnt    = dg_q;

  always_comb begin
    pv_d      = '0;
    po_d      = '0;
    pipe_busy = 1'b0;
    pv_d[0]   = acc & ~we_q;
    po_d[0]   = own_q;
    for (int i = 1; i < L; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
    end
    for (int i = 0; i < L - 1; i++) begin
      pipe_busy = pipe_busy | pv_q[i];
    end
  end

  assign d_win = d_req & ((starve_q < SW'(STARVE_LIMIT)) | ~f_req);

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    we_d     = we_q;
    base_d   = base_q;
    size_d   = size_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    fg_d     = 1'b0;
    dg_d     = 1'b0;
    starve_d = f_req ? starve_q : '0;
    unique case (state_q)
      S_IDLE: begin
        if (d_win) begin
          dg_d    = 1'b1;
          own_d   = 1'b1;
          we_d    = d_we;
          base_d  = d_addr;
          size_d  = d_acc_size;
          k_d     = 4'd0;
          cnt_d   = last_beat(d_acc_size);
          state_d = S_BURST;
          if (f_req) starve_d = starve_q + 1'b1;
        end else if (f_req) begin
          fg_d     = 1'b1;
          own_d    = 1'b0;
          we_d     = 1'b0;
          base_d   = f_addr;
          size_d   = f_acc_size;
          k_d      = 4'd0;
          cnt_d    = last_beat(f_acc_size);
          state_d  = S_BURST;
          starve_d = '0;
        end
      end
      S_BURST: begin
        if (acc) begin
          k_d   = k_q + 4'd1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = we_q ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Final beat returns this cycle once earlier stages are empty.
        if (!pipe_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      size_q   <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      fg_q     <= 1'b0;
      dg_q     <= 1'b0;
      starve_q <= '0;
      pv_q     <= '0;
      po_q     <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      we_q     <= we_d;
      base_q   <= base_d;
      size_q   <= size_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      fg_q     <= fg_d;
      dg_q     <= dg_d;
      starve_q <= starve_d;
      pv_q     <= pv_d;
      po_q     <= po_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a
// transaction-level model with a memory shadow.
module tb_mem_port_arbiter;

  localparam int L  = 1;
  localparam int SL = 4;

  logic        clock;
  logic        reset_n;
  logic        f_req, f_gnt, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic [1:0]  f_acc_size;
  logic        d_req, d_we, d_wnext, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_acc_size;
  logic        mem_enable, mem_wren, mem_busy;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0]  mem_acc_size;

  mem_port_arbiter #(.READ_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_acc_size(f_acc_size),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_acc_size(d_acc_size), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_wren(mem_wren),
    .mem_acc_size(mem_acc_size), .mem_data_out(mem_data_out),
    .mem_busy(mem_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int c; bit own; logic [31:0] a; } ret_t;
  typedef struct { int c; logic [31:0] a; } rd_t;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit rst_val = 1'b0;
  int busy_pct = 0, busy_force = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] sh  [logic [31:0]];
  rd_t  rdq[$];

  bit m_act, m_own, m_we, m_gown;
  logic [31:0] m_base;
  logic [1:0]  m_size;
  int m_n, m_k, m_gcyc = -1, m_idle_at = 0, m_starve = 0;
  ret_t retq[$];

  bit fp, fi, dp, di, dw, auto_f, auto_d;
  int fleft, dleft, widx, prob;
  logic [31:0] fa, da;
  logic [1:0]  fs, ds;
  logic [31:0] wv [16];

  logic [31:0] f_log[$], d_log[$];
  bit glog[$];
  int f_gnt_cyc = -1, d_gnt_cyc = -1, f_last_rv = -1;
  int n_wnext = 0, n_drv = 0, n_frv = 0;

  function automatic int nbeats(logic [1:0] s);
    return (s == 2'b00) ? 1 : (2 << s);
  endfunction

  function automatic logic [31:0] memrd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] shrd(logic [31:0] a);
    return sh.exists(a) ? sh[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0;
    return 32'h8002_0000 + (32'($urandom_range(0, 255)) << 2);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
  endtask

  task automatic req_f(logic [31:0] a, logic [1:0] s);
    fp = 1; fa = a; fs = s;
  endtask

  task automatic req_d(bit w, logic [31:0] a, logic [1:0] s);
    dp = 1; dw = w; da = a; ds = s; widx = 0;
  endtask

  task automatic compare();
    logic efg, edg, efr, edr, en, wr, wn;
    logic [31:0] erd;
    efg = 0; edg = 0; efr = 0; edr = 0;
    en = 0; wr = 0; wn = 0; erd = '0;
    if (reset_n) begin
      en  = m_act;
      wr  = m_act && m_we;
      wn  = wr && !mem_busy;
      efg = (m_gcyc == cyc) && !m_gown;
      edg = (m_gcyc == cyc) && m_gown;
      if (retq.size() > 0 && retq[0].c == cyc) begin
        efr = !retq[0].own;
        edr = retq[0].own;
        erd = shrd(retq[0].a);
      end
    end
    chk("f_gnt", 32'(f_gnt), 32'(efg));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    chk("f_rvalid", 32'(f_rvalid), 32'(efr));
    chk("d_rvalid", 32'(d_rvalid), 32'(edr));
    chk("mem_enable", 32'(mem_enable), 32'(en));
    chk("mem_wren", 32'(mem_wren), 32'(wr));
    chk("d_wnext", 32'(d_wnext), 32'(wn));
    if (en) begin
      chk("mem_addr", mem_addr, m_base + 32'(4 * m_k));
      chk("mem_acc_size", 32'(mem_acc_size), 32'(m_size));
    end
    if (wr) chk("mem_data_in", mem_data_in, d_wdata);
    if (efr) chk("f_rdata", f_rdata, erd);
    if (edr) chk("d_rdata", d_rdata, erd);
    if (!reset_n) begin
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_data_in", mem_data_in, 32'h0);
      chk("rst_acc_size", 32'(mem_acc_size), 32'h0);
      chk("rst_f_rdata", f_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
    end
  endtask

  task automatic start(bit own, bit w, logic [31:0] a, logic [1:0] s);
    m_act = 1; m_own = own; m_we = w; m_base = a; m_size = s;
    m_n = nbeats(s); m_k = 0; m_gcyc = cyc + 1; m_gown = own;
  endtask

  task automatic model_update();
    bit was;
    logic [31:0] a;
    if (!reset_n) begin
      m_act = 0; retq.delete(); m_starve = 0;
      m_gcyc = -1; m_idle_at = 0;
      return;
    end
    if (retq.size() > 0 && retq[0].c == cyc) retq.delete(0);
    was = m_act;
    if (m_act && !mem_busy) begin
      a = m_base + 32'(4 * m_k);
      if (m_we) sh[a] = d_wdata;
      else retq.push_back('{c: cyc + L, own: m_own, a: a});
      m_k++;
      if (m_k == m_n) begin
        m_act = 0;
        m_idle_at = m_we ? cyc + 1 : cyc + L + 1;
      end
    end
    if (!was && cyc >= m_idle_at) begin
      if (d_req && (m_starve < SL || !f_req)) begin
        start(1, d_we, d_addr, d_acc_size);
        if (f_req) m_starve++;
      end else if (f_req) begin
        start(0, 0, f_addr, f_acc_size);
        m_starve = 0;
      end
    end
    if (!f_req) m_starve = 0;
  endtask

  task automatic observe();
    if (!reset_n) begin
      fp = 0; fi = 0; dp = 0; di = 0; widx = 0;
      return;
    end
    if (f_gnt) begin
      fp = 0; fi = 1; fleft = nbeats(fs);
      glog.push_back(1'b0); f_gnt_cyc = cyc;
    end
    if (f_rvalid) begin
      f_log.push_back(f_rdata); n_frv++; f_last_rv = cyc;
      fleft--; if (fleft <= 0) fi = 0;
    end
    if (d_gnt) begin
      dp = 0; di = 1; dleft = nbeats(ds);
      glog.push_back(1'b1); d_gnt_cyc = cyc;
    end
    if (d_wnext) begin
      widx++; n_wnext++;
      dleft--; if (dleft <= 0) di = 0;
    end
    if (d_rvalid) begin
      d_log.push_back(d_rdata); n_drv++;
      dleft--; if (dleft <= 0) di = 0;
    end
    if (auto_f && !fp && !fi && $urandom_range(0, 99) < prob)
      req_f(rand_addr(), 2'($urandom_range(0, 3)));
    if (auto_d && !dp && !di && $urandom_range(0, 99) < prob) begin
      for (int i = 0; i < 16; i++) wv[i] = $urandom;
      req_d(1'($urandom_range(0, 1)), rand_addr(),
            2'($urandom_range(0, 3)));
    end
  endtask

  task automatic env_update();
    if (!reset_n) begin
      rdq.delete();
      return;
    end
    if (mem_enable && !mem_busy) begin
      if (mem_wren) mem[mem_addr] = mem_data_in;
      else rdq.push_back('{c: cyc + L, a: mem_addr});
    end
  endtask

  task automatic step();
    @(negedge clock);
    reset_n = rst_val;
    mem_busy = 1'b0;
    if (busy_force > 0) begin
      mem_busy = 1'b1;
      busy_force--;
    end else if ($urandom_range(0, 99) < busy_pct) begin
      mem_busy = 1'b1;
    end
    mem_data_out = $urandom;
    if (rdq.size() > 0 && rdq[0].c == cyc) begin
      mem_data_out = memrd(rdq[0].a);
      rdq.delete(0);
    end
    f_req = fp; f_addr = fa; f_acc_size = fs;
    d_req = dp; d_we = dw; d_addr = da; d_acc_size = ds;
    d_wdata = (widx < 16) ? wv[widx] : 32'h0;
    #1;
    compare();
    observe();
    model_update();
    env_update();
    cyc++;
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while ((fp || fi || dp || di || m_act || retq.size() > 0)
           && n < bound) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < bound), 32'h1);
    step();
    step();
  endtask

  initial begin
    int rc, n, b;
    fp = 0; fi = 0; dp = 0; di = 0; dw = 0; widx = 0;
    fa = '0; da = '0; fs = '0; ds = '0; prob = 0;
    auto_f = 0; auto_d = 0;
    for (int i = 0; i < 16; i++) wv[i] = '0;
    reset_n = 1'b0; mem_busy = 1'b0; mem_data_out = '0;
    f_req = 0; d_req = 0; f_addr = '0; d_addr = '0;
    f_acc_size = '0; d_acc_size = '0; d_we = 0; d_wdata = '0;

    rst_val = 0;
    repeat (3) step();
    rst_val = 1;
    repeat (2) step();

    // 1: single fetch word
    f_log.delete();
    rc = cyc;
    req_f(32'h8002_0000, 2'b00);
    wait_idle(50);
    chk("t1_gnt_lat", 32'(f_gnt_cyc - rc), 32'd1);
    chk("t1_rv_lat", 32'(f_last_rv - rc), 32'd2);
    chk("t1_count", 32'(f_log.size()), 32'd1);
    if (f_log.size() > 0) chk("t1_data", f_log[0], 32'h25A7_0000);

    // 2: 4-beat write then fetch readback
    wv[0] = 32'h11; wv[1] = 32'h22; wv[2] = 32'h33; wv[3] = 32'h44;
    n = n_wnext;
    req_d(1, 32'h8002_0010, 2'b01);
    wait_idle(50);
    chk("t2_wnext", 32'(n_wnext - n), 32'd4);
    f_log.delete();
    req_f(32'h8002_0010, 2'b01);
    wait_idle(50);
    chk("t2_count", 32'(f_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < f_log.size(); i++)
      chk("t2_data", f_log[i], 32'(8'h11 * (i + 1)));

    // 3: both requesters continuously pending
    glog.delete();
    auto_f = 1; auto_d = 1; prob = 100;
    req_f(rand_addr(), 2'b01);
    req_d(0, rand_addr(), 2'b00);
    n = 0;
    while (glog.size() < 10 && n < 3000) begin
      step();
      n++;
    end
    auto_f = 0; auto_d = 0;
    wait_idle(200);
    chk("t3_grants", 32'(glog.size() >= 10), 32'h1);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk("t3_pattern", 32'(glog[i]), 32'((i % 5) != 4));

    // 4: stall mid 8-beat read
    n = n_drv;
    req_d(0, 32'h8002_0100, 2'b10);
    b = 0;
    while (!(m_act && m_k == 3) && b < 50) begin
      step();
      b++;
    end
    busy_force = 3;
    wait_idle(80);
    chk("t4_rvalids", 32'(n_drv - n), 32'd8);

    // 5: reset during beat 2 of a 16-beat read
    req_d(0, 32'h8002_0400, 2'b11);
    b = 0;
    while (!(m_act && m_k == 2) && b < 50) begin
      step();
      b++;
    end
    chk("t5_reached", 32'(m_act && m_k == 2), 32'h1);
    rst_val = 0;
    repeat (3) step();
    rst_val = 1;
    n = n_drv + n_frv;
    repeat (20) step();
    chk("t5_no_rvalid", 32'(n_drv + n_frv - n), 32'd0);

    // 6: data request arriving during a fetch burst
    req_f(32'h8002_0200, 2'b10);
    b = 0;
    while (!m_act && b < 20) begin
      step();
      b++;
    end
    req_d(0, 32'h8002_0300, 2'b00);
    wait_idle(80);
    chk("t6_dgnt_after_drain", 32'(d_gnt_cyc - f_last_rv), 32'd2);

    // random traffic with stalls
    auto_f = 1; auto_d = 1; prob = 30; busy_pct = 25;
    repeat (3000) step();
    auto_f = 0; auto_d = 0;
    wait_idle(500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
